// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs immediate and register/funct fields into an
// instruction word of the selected format, buffered in a 2-entry output FIFO.
module imm_encoder #(
    parameter int CNT_W    = 16,
    parameter int ERRCNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [2:0]          i_imm_sel,
    input  logic [31:0]         i_imm,
    input  logic [6:0]          i_opcode,
    input  logic [4:0]          i_rd,
    input  logic [4:0]          i_rs1,
    input  logic [4:0]          i_rs2,
    input  logic [2:0]          i_funct3,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [31:0]         o_inst,
    output logic                o_err,
    output logic [CNT_W-1:0]    o_enc_cnt,
    output logic [ERRCNT_W-1:0] o_err_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Returns {err, inst}; rejected requests carry a NOP so the word is always executable.
    function automatic logic [32:0] encode(
        input logic [2:0]  sel,
        input logic [31:0] imm,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3
    );
        logic        bad;
        logic [31:0] inst;
        bad  = 1'b0;
        inst = NOP;
        case (sel)
            3'b000: begin
                bad  = !((&imm[31:11]) || !(|imm[31:11]));
                inst = {imm[11:0], rs1, f3, rd, op};
            end
            3'b001: begin
                bad  = !((&imm[31:11]) || !(|imm[31:11]));
                inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            3'b010: begin
                bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
                inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            3'b011: begin
                bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            3'b100, 3'b101: begin
                bad  = |imm[11:0];
                inst = {imm[31:12], rd, op};
            end
            default: bad = 1'b1;
        endcase
        if (bad) inst = NOP;
        return {bad, inst};
    endfunction

    logic [32:0]         mem0_q, mem0_d;
    logic [32:0]         mem1_q, mem1_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [CNT_W-1:0]    enc_cnt_q, enc_cnt_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [32:0]         entry;
    logic                push, pop;

    assign o_ready   = (count_q != 2'd2);
    assign o_valid   = (count_q != 2'd0);
    assign {o_err, o_inst} = rd_ptr_q ? mem1_q : mem0_q;
    assign o_enc_cnt = enc_cnt_q;
    assign o_err_cnt = err_cnt_q;

    assign entry = encode(i_imm_sel, i_imm, i_opcode, i_rd, i_rs1, i_rs2, i_funct3);
    assign push  = i_valid && o_ready;
    assign pop   = o_valid && i_ready;

    always_comb begin
        mem0_d    = mem0_q;
        mem1_d    = mem1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            if (wr_ptr_q) mem1_d = entry;
            else          mem0_d = entry;
            wr_ptr_d = !wr_ptr_q;
            if (!entry[32])       enc_cnt_d = enc_cnt_q + 1'b1;
            else if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        // Push and pop together leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem0_q    <= '0;
            mem1_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            mem0_q    <= mem0_d;
            mem1_q    <= mem1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: hand-computed encodings, error handling,
// FIFO backpressure/ordering, reset flush and error-counter saturation.
module tb_imm_encoder;

    logic        clk;
    logic        i_reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_imm_sel;
    logic [31:0] i_imm;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic        o_err;
    logic [15:0] o_enc_cnt;
    logic [7:0]  o_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    imm_encoder #(.CNT_W(16), .ERRCNT_W(8)) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_imm_sel (i_imm_sel),
        .i_imm     (i_imm),
        .i_opcode  (i_opcode),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_funct3  (i_funct3),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_inst    (o_inst),
        .o_err     (o_err),
        .o_enc_cnt (o_enc_cnt),
        .o_err_cnt (o_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3);
        i_imm_sel = sel;
        i_imm     = imm;
        i_opcode  = op;
        i_rd      = rd;
        i_rs1     = rs1;
        i_rs2     = rs2;
        i_funct3  = f3;
        i_valid   = 1'b1;
    endtask

    task automatic req(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3);
        drive(sel, imm, op, rd, rs1, rs2, f3);
        step();
        i_valid  = 1'b0;
        i_imm    = 32'hDEAD_BEEF;
        i_opcode = 7'h7F;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] inst, input logic err);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_inst"}, o_inst, inst);
        check({tag, "_err"}, {31'd0, o_err}, {31'd0, err});
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_imm_sel = '0;
        i_imm     = '0;
        i_opcode  = '0;
        i_rd      = '0;
        i_rs1     = '0;
        i_rs2     = '0;
        i_funct3  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_inst", o_inst, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_enc_cnt", {16'd0, o_enc_cnt}, 32'd0);
        check("rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
        i_reset_n = 1'b1;
        step();

        // Good encodes, each popped right after its one-cycle latency.
        req(3'b000, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        pop_expect("addi", 32'hFFF0_0093, 1'b0);
        check("addi_empty", {31'd0, o_valid}, 32'd0);
        req(3'b001, 32'h0000_0008, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2);
        pop_expect("sw", 32'h0020_A423, 1'b0);
        req(3'b010, 32'h0000_0008, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        pop_expect("beq", 32'h0020_8463, 1'b0);
        req(3'b011, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        pop_expect("jal", 32'h0010_00EF, 1'b0);
        req(3'b100, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        pop_expect("lui", 32'h1234_52B7, 1'b0);
        req(3'b101, 32'hFFFF_F000, 7'h17, 5'd3, 5'd0, 5'd0, 3'd0);
        pop_expect("auipc", 32'hFFFF_F197, 1'b0);
        check("enc_cnt6", {16'd0, o_enc_cnt}, 32'd6);
        req(3'b100, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        pop_expect("lui_bad", 32'h0000_0013, 1'b1);
        check("lui_bad_errcnt", {24'd0, o_err_cnt}, 32'd1);
        check("lui_bad_enccnt", {16'd0, o_enc_cnt}, 32'd6);

        i_reset_n = 1'b0;
        #2;
        i_reset_n = 1'b1;
        step();

        req(3'b010, 32'h0000_0003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        pop_expect("b_odd", 32'h0000_0013, 1'b1);
        req(3'b000, 32'h0000_0800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        pop_expect("i_range", 32'h0000_0013, 1'b1);
        req(3'b111, 32'h0000_0000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        pop_expect("sel_ill", 32'h0000_0013, 1'b1);
        check("err3_errcnt", {24'd0, o_err_cnt}, 32'd3);
        check("err3_enccnt", {16'd0, o_enc_cnt}, 32'd0);

        // Three back-to-back requests with the consumer stalled: third is refused.
        drive(3'b000, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        step();
        drive(3'b100, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        step();
        check("bp_full_ready", {31'd0, o_ready}, 32'd0);
        drive(3'b011, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        step();
        i_valid = 1'b0;
        check("bp_still_full", {31'd0, o_ready}, 32'd0);
        check("bp_enccnt", {16'd0, o_enc_cnt}, 32'd2);
        step();
        check("bp_hold_inst", o_inst, 32'hFFF0_0093);
        pop_expect("bp_a", 32'hFFF0_0093, 1'b0);
        check("bp_ready_after_pop", {31'd0, o_ready}, 32'd1);
        pop_expect("bp_b", 32'h1234_52B7, 1'b0);
        check("bp_empty", {31'd0, o_valid}, 32'd0);

        // Push and pop in the same cycle keep one entry, now the newer one.
        req(3'b010, 32'h0000_0008, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        drive(3'b011, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("pp_ready", {31'd0, o_ready}, 32'd1);
        pop_expect("pp_head", 32'h0010_00EF, 1'b0);
        check("pp_empty", {31'd0, o_valid}, 32'd0);

        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("empty_pop_valid", {31'd0, o_valid}, 32'd0);
        check("empty_pop_ready", {31'd0, o_ready}, 32'd1);

        // Asynchronous reset with two entries buffered clears everything at once.
        req(3'b000, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        req(3'b100, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        check("pre_rst_ready", {31'd0, o_ready}, 32'd0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        check("mid_rst_enccnt", {16'd0, o_enc_cnt}, 32'd0);
        check("mid_rst_inst", o_inst, 32'd0);
        i_reset_n = 1'b1;
        step();

        // Error counter saturates at all-ones.
        drive(3'b110, 32'h0000_0000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        i_ready = 1'b1;
        repeat (300) step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("sat_errcnt", {24'd0, o_err_cnt}, 32'hFF);
        check("sat_enccnt", {16'd0, o_enc_cnt}, 32'd0);
        pop_expect("sat_last", 32'h0000_0013, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
